// File: rtl/m_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_pkg
// Description : Shared RV32M funct3 codes and issue-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package m_ext_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2,
        WB    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/m_ext_result_cache.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_result_cache
// Description : One-entry cache of the last RV32M result, tagged by funct3/rs1/rs2.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ext_result_cache #(
    parameter int INPUT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   i_clear,
    input  logic [2:0]             i_lookup_funct3,
    input  logic [INPUT_WIDTH-1:0] i_lookup_rs1,
    input  logic [INPUT_WIDTH-1:0] i_lookup_rs2,
    output logic                   o_hit,
    output logic [INPUT_WIDTH-1:0] o_data,
    input  logic                   i_update,
    input  logic [2:0]             i_update_funct3,
    input  logic [INPUT_WIDTH-1:0] i_update_rs1,
    input  logic [INPUT_WIDTH-1:0] i_update_rs2,
    input  logic [INPUT_WIDTH-1:0] i_update_result
);

    logic                   r_valid_q,  w_valid_d;
    logic [2:0]             r_funct3_q, w_funct3_d;
    logic [INPUT_WIDTH-1:0] r_rs1_q,    w_rs1_d;
    logic [INPUT_WIDTH-1:0] r_rs2_q,    w_rs2_d;
    logic [INPUT_WIDTH-1:0] r_data_q,   w_data_d;

    always_comb begin
        w_valid_d  = r_valid_q;
        w_funct3_d = r_funct3_q;
        w_rs1_d    = r_rs1_q;
        w_rs2_d    = r_rs2_q;
        w_data_d   = r_data_q;
        if (i_update) begin
            w_valid_d  = 1'b1;
            w_funct3_d = i_update_funct3;
            w_rs1_d    = i_update_rs1;
            w_rs2_d    = i_update_rs2;
            w_data_d   = i_update_result;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_valid_q  <= 1'b0;
            r_funct3_q <= '0;
            r_rs1_q    <= '0;
            r_rs2_q    <= '0;
            r_data_q   <= '0;
        end else begin
            r_valid_q  <= w_valid_d;
            r_funct3_q <= w_funct3_d;
            r_rs1_q    <= w_rs1_d;
            r_rs2_q    <= w_rs2_d;
            r_data_q   <= w_data_d;
        end
    end

    assign o_hit  = r_valid_q && (r_funct3_q == i_lookup_funct3)
                 && (r_rs1_q == i_lookup_rs1) && (r_rs2_q == i_lookup_rs2);
    assign o_data = r_data_q;

endmodule
`default_nettype wire

// File: rtl/m_ext_issue.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_issue
// Description : Issue/writeback wrapper around the RV32M unit with flush and result cache.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ext_issue
    import m_ext_pkg::*;
#(
    parameter int INPUT_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ISSUE_VALID,
    input  logic [2:0]                ISSUE_FUNCT3,
    input  logic [INPUT_WIDTH-1:0]    ISSUE_RS1,
    input  logic [INPUT_WIDTH-1:0]    ISSUE_RS2,
    input  logic [REG_ADDR_WIDTH-1:0] ISSUE_RD,
    input  logic                      FLUSH,
    input  logic                      PIPE_STALL,
    output logic                      BUSY,
    output logic                      M_START,
    output logic [2:0]                M_CNT,
    output logic [INPUT_WIDTH-1:0]    M_RS1,
    output logic [INPUT_WIDTH-1:0]    M_RS2,
    output logic                      M_STALL,
    input  logic [INPUT_WIDTH-1:0]    M_OUT,
    input  logic                      M_READY,
    output logic                      WB_VALID,
    output logic [REG_ADDR_WIDTH-1:0] WB_RD,
    output logic [INPUT_WIDTH-1:0]    WB_DATA
);

    state_t                    r_state_q,    w_state_d;
    logic [2:0]                r_funct3_q,   w_funct3_d;
    logic [INPUT_WIDTH-1:0]    r_rs1_q,      w_rs1_d;
    logic [INPUT_WIDTH-1:0]    r_rs2_q,      w_rs2_d;
    logic [REG_ADDR_WIDTH-1:0] r_rd_q,       w_rd_d;
    logic [INPUT_WIDTH-1:0]    r_wb_data_q,  w_wb_data_d;
    logic                      r_busy_q,     w_busy_d;
    logic                      r_start_q,    w_start_d;
    logic                      r_wb_valid_q, w_wb_valid_d;

    logic                      w_accept;
    logic                      w_hit;
    logic [INPUT_WIDTH-1:0]    w_hit_data;
    logic                      w_cache_update;

    m_ext_result_cache #(
        .INPUT_WIDTH (INPUT_WIDTH)
    ) u_cache (
        .clk             (CLK),
        .i_clear         (RST),
        .i_lookup_funct3 (ISSUE_FUNCT3),
        .i_lookup_rs1    (ISSUE_RS1),
        .i_lookup_rs2    (ISSUE_RS2),
        .o_hit           (w_hit),
        .o_data          (w_hit_data),
        .i_update        (w_cache_update),
        .i_update_funct3 (r_funct3_q),
        .i_update_rs1    (r_rs1_q),
        .i_update_rs2    (r_rs2_q),
        .i_update_result (M_OUT)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_funct3_d  = r_funct3_q;
        w_rs1_d     = r_rs1_q;
        w_rs2_d     = r_rs2_q;
        w_rd_d      = r_rd_q;
        w_wb_data_d = r_wb_data_q;

        w_accept       = ISSUE_VALID && (r_state_q == IDLE) && !FLUSH;
        // RV32M cannot be aborted, so a result still lands in the cache while draining.
        w_cache_update = M_READY && ((r_state_q == EXEC) || (r_state_q == DRAIN));

        if (w_accept) begin
            w_funct3_d = ISSUE_FUNCT3;
            w_rs1_d    = ISSUE_RS1;
            w_rs2_d    = ISSUE_RS2;
            w_rd_d     = ISSUE_RD;
        end

        case (r_state_q)
            IDLE: begin
                if (w_accept && (ISSUE_RD != '0)) begin
                    if (w_hit) begin
                        w_state_d   = WB;
                        w_wb_data_d = w_hit_data;
                    end else begin
                        w_state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (M_READY) begin
                    if (FLUSH) begin
                        w_state_d   = IDLE;
                    end else begin
                        w_state_d   = WB;
                        w_wb_data_d = M_OUT;
                    end
                end else if (FLUSH) begin
                    w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (M_READY) begin
                    w_state_d = IDLE;
                end
            end
            WB: begin
                if (FLUSH || !PIPE_STALL) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_busy_d     = (w_state_d != IDLE);
        w_start_d    = (w_state_d == EXEC) || (w_state_d == DRAIN);
        w_wb_valid_d = (w_state_d == WB);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q    <= IDLE;
            r_funct3_q   <= '0;
            r_rs1_q      <= '0;
            r_rs2_q      <= '0;
            r_rd_q       <= '0;
            r_wb_data_q  <= '0;
            r_busy_q     <= 1'b0;
            r_start_q    <= 1'b0;
            r_wb_valid_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_funct3_q   <= w_funct3_d;
            r_rs1_q      <= w_rs1_d;
            r_rs2_q      <= w_rs2_d;
            r_rd_q       <= w_rd_d;
            r_wb_data_q  <= w_wb_data_d;
            r_busy_q     <= w_busy_d;
            r_start_q    <= w_start_d;
            r_wb_valid_q <= w_wb_valid_d;
        end
    end

    assign BUSY     = r_busy_q;
    assign M_START  = r_start_q;
    assign M_CNT    = r_funct3_q;
    assign M_RS1    = r_rs1_q;
    assign M_RS2    = r_rs2_q;
    assign M_STALL  = PIPE_STALL;
    assign WB_VALID = r_wb_valid_q;
    assign WB_RD    = r_rd_q;
    assign WB_DATA  = r_wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_m_ext_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_ext_issue
// Description : Randomized self-checking bench with an RV32M stand-in and a result model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_m_ext_issue;
    import m_ext_pkg::*;

    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [2:0]    issue_funct3;
    logic [W-1:0]  issue_rs1, issue_rs2;
    logic [RW-1:0] issue_rd;
    logic          flush, pipe_stall;
    logic          busy, m_start, m_stall;
    logic [2:0]    m_cnt;
    logic [W-1:0]  m_rs1, m_rs2;
    logic [W-1:0]  m_out   = '0;
    logic          m_ready = 1'b0;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [W-1:0]  wb_data;

    always #5 clk = ~clk;

    m_ext_issue #(.INPUT_WIDTH(W), .REG_ADDR_WIDTH(RW)) dut (
        .CLK(clk), .RST(rst),
        .ISSUE_VALID(issue_valid), .ISSUE_FUNCT3(issue_funct3),
        .ISSUE_RS1(issue_rs1), .ISSUE_RS2(issue_rs2), .ISSUE_RD(issue_rd),
        .FLUSH(flush), .PIPE_STALL(pipe_stall),
        .BUSY(busy), .M_START(m_start), .M_CNT(m_cnt),
        .M_RS1(m_rs1), .M_RS2(m_rs2), .M_STALL(m_stall),
        .M_OUT(m_out), .M_READY(m_ready),
        .WB_VALID(wb_valid), .WB_RD(wb_rd), .WB_DATA(wb_data)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    // Architectural RV32M result, including divide-by-zero and overflow cases.
    function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        logic signed [31:0] a32, b32, q32;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        a32 = a;
        b32 = b;
        case (f)
            MUL:    begin sp = sa * sb; return sp[31:0]; end
            MULH:   begin sp = sa * sb; return sp[63:32]; end
            MULHSU: begin sp = sa * $signed(ua); return sp[63:32]; end
            MULHU:  begin up = ua * ub; return up[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q32 = a32 / b32; return q32;
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q32 = a32 % b32; return q32;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // RV32M stand-in: READY after mlat cycles of START, held until START drops.
    int mlat = 1;
    int mcnt = 0;
    always @(posedge clk) begin
        #1;
        if (m_start) begin
            mcnt++;
            if (mcnt >= mlat) begin
                m_ready = 1'b1;
                m_out   = ref_op(m_cnt, m_rs1, m_rs2);
            end
        end else begin
            mcnt    = 0;
            m_ready = 1'b0;
            m_out   = $urandom;
        end
    end

    // Expected model state.
    typedef struct { logic [RW-1:0] rd; logic [W-1:0] data; } wb_t;
    wb_t         exp_q[$];
    bit          c_valid = 1'b0;
    logic [2:0]  c_f3;
    logic [W-1:0] c_a, c_b, c_res;
    logic [2:0]  exp_f3 = '0;
    logic [W-1:0] exp_a = '0, exp_b = '0;
    logic [W-1:0] last_wb;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_stall_copy", 32'(m_stall), 32'(pipe_stall));
            if (m_start) begin
                chk("m_cnt_held", 32'(m_cnt), 32'(exp_f3));
                chk("m_rs1_held", m_rs1, exp_a);
                chk("m_rs2_held", m_rs2, exp_b);
            end
            if ((m_start || wb_valid) && !busy)
                chk("busy_when_active", 32'(busy), 32'd1);
            if (wb_valid && !pipe_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got rd %0d data 0x%08h, required no writeback", wb_rd, wb_data);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [RW-1:0] rd, input int lat, input int flush_cyc,
                            input int stall_n, input bit flush_wb);
        int g;
        int n;
        bit hit;
        logic [W-1:0] res, exp_data;
        g = 0;
        while (busy && g < 200) begin tick(); g++; end
        chk("idle_before_issue", 32'(busy), 32'd0);
        hit      = c_valid && (c_f3 == f3) && (c_a == a) && (c_b == b);
        res      = ref_op(f3, a, b);
        exp_data = hit ? c_res : res;
        if (lat <= 0) lat = $urandom_range(1, 6);
        mlat = lat;
        if (!hit && rd != 0) begin exp_f3 = f3; exp_a = a; exp_b = b; end
        issue_valid = 1'b1; issue_funct3 = f3; issue_rs1 = a; issue_rs2 = b; issue_rd = rd;
        tick();
        issue_valid = 1'b0; issue_funct3 = 3'($urandom); issue_rs1 = $urandom;
        issue_rs2 = $urandom; issue_rd = 5'($urandom);
        if (rd == 0) begin
            repeat (3) begin
                chk("rd0_busy", 32'(busy), 32'd0);
                chk("rd0_start", 32'(m_start), 32'd0);
                chk("rd0_wb_valid", 32'(wb_valid), 32'd0);
                tick();
            end
            return;
        end
        if (hit) begin
            chk("hit_start", 32'(m_start), 32'd0);
            chk("hit_wb_valid", 32'(wb_valid), 32'd1);
            chk("hit_wb_data", wb_data, exp_data);
        end else begin
            chk("launch_start", 32'(m_start), 32'd1);
            chk("launch_wb_valid", 32'(wb_valid), 32'd0);
            if (flush_cyc >= 0) begin
                if (flush_cyc > lat - 1) flush_cyc = lat - 1;
                repeat (flush_cyc) tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
                g = 0;
                while (busy && g < 50) begin
                    chk("drain_no_wb", 32'(wb_valid), 32'd0);
                    tick();
                    g++;
                end
                chk("flush_idle", 32'(busy), 32'd0);
                c_valid = 1'b1; c_f3 = f3; c_a = a; c_b = b; c_res = res;
                return;
            end
            n = 1;
            while (!wb_valid && n < 50) begin tick(); n++; end
            chk("launch_latency", 32'(n), 32'(lat + 1));
            c_valid = 1'b1; c_f3 = f3; c_a = a; c_b = b; c_res = res;
        end
        if (flush_wb) begin
            pipe_stall = 1'b1;
            flush      = 1'b1;
            tick();
            pipe_stall = 1'b0;
            flush      = 1'b0;
            chk("wb_flush_valid", 32'(wb_valid), 32'd0);
            chk("wb_flush_busy", 32'(busy), 32'd0);
            return;
        end
        exp_q.push_back('{rd: rd, data: exp_data});
        last_wb = wb_data;
        for (int i = 0; i < stall_n; i++) begin
            pipe_stall = 1'b1;
            chk("stall_wb_valid", 32'(wb_valid), 32'd1);
            chk("stall_wb_data", wb_data, exp_data);
            tick();
        end
        pipe_stall = 1'b0;
        chk("wb_valid_last", 32'(wb_valid), 32'd1);
        tick();
        chk("wb_released", 32'(wb_valid), 32'd0);
        chk("idle_after_wb", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_funct3 = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_rd = '0; flush = 1'b0; pipe_stall = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(m_start), 32'd0);
        chk("rst_m_cnt", 32'(m_cnt), 32'd0);
        chk("rst_m_rs1", m_rs1, 32'd0);
        chk("rst_m_rs2", m_rs2, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_issue(MUL, 32'd7, 32'd6, 5'd5, 4, -1, 0, 1'b0);
        chk("mul_7x6", last_wb, 32'd42);
        do_issue(MUL, 32'd7, 32'd6, 5'd9, 0, -1, 0, 1'b0);
        chk("mul_7x6_hit", last_wb, 32'd42);
        do_issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 5, 1, 0, 1'b0);
        do_issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0, -1, 0, 1'b0);
        chk("div_ovf_hit", last_wb, 32'h8000_0000);
        do_issue(REMU, 32'd100, 32'd7, 5'd6, 3, -1, 3, 1'b0);
        chk("remu_100_7", last_wb, 32'd2);
        do_issue(MULHU, 32'hFFFF_FFFF, 32'd2, 5'd0, 2, -1, 0, 1'b0);

        // Reset during EXEC; the previously cached REMU must then relaunch.
        exp_f3 = MUL; exp_a = 32'd3; exp_b = 32'd5; mlat = 6;
        issue_valid = 1'b1; issue_funct3 = MUL; issue_rs1 = 32'd3; issue_rs2 = 32'd5; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        tick();
        chk("pre_rst_start", 32'(m_start), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_start", 32'(m_start), 32'd0);
        chk("midrst_m_cnt", 32'(m_cnt), 32'd0);
        chk("midrst_m_rs1", m_rs1, 32'd0);
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        c_valid = 1'b0;
        do_issue(REMU, 32'd100, 32'd7, 5'd8, 2, -1, 0, 1'b0);
        chk("remu_after_rst", last_wb, 32'd2);
        do_issue(MUL, 32'd3, 32'd5, 5'd7, 0, -1, 1, 1'b0);
        chk("mul_after_rst", last_wb, 32'd15);

        for (int it = 0; it < 80; it++) begin
            logic [2:0]    f;
            logic [W-1:0]  a, b;
            logic [RW-1:0] rd;
            int            fc;
            if (c_valid && $urandom_range(0, 3) == 0) begin
                f = c_f3; a = c_a; b = c_b;
            end else begin
                f = 3'($urandom); a = pick(); b = pick();
            end
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            fc = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 5)) : -1;
            do_issue(f, a, b, rd, 0, fc, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end

        repeat (3) tick();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_ext_issue.md
# m_ext_issue

Issue/writeback stage wrapped around the RV32M multiply/divide unit in the execute stage. Accepts one M-extension instruction from decode, holds funct3 and operands stable on the RV32M inputs until its READY, and presents the registered result with its destination register to writeback. Also provides:
- pipeline back-pressure (BUSY);
- flush handling, since RV32M cannot be aborted;
- a one-entry result cache for repeated identical operations.

## Interface
Parameters:
- INPUT_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ISSUE_VALID  in  1  decode presents an M-extension instruction.
- ISSUE_FUNCT3  in  3  operation (MUL..REMU encoding).
- ISSUE_RS1, ISSUE_RS2  in  INPUT_WIDTH  operand values.
- ISSUE_RD  in  REG_ADDR_WIDTH  destination register.
- FLUSH  in  1  squash the in-flight instruction.
- PIPE_STALL  in  1  writeback cannot accept this cycle.
- BUSY  out  1  stage occupied; decode must hold its instruction.
- M_START  out  1  to RV32M START.
- M_CNT  out  3  to RV32M M_CNT.
- M_RS1, M_RS2  out  INPUT_WIDTH  to RV32M RS1/RS2.
- M_STALL  out  1  to RV32M STALL_M_STD; combinational copy of PIPE_STALL.
- M_OUT  in  INPUT_WIDTH  from RV32M OUT.
- M_READY  in  1  from RV32M READY.
- WB_VALID  out  1  result available for writeback.
- WB_RD  out  REG_ADDR_WIDTH  destination of the result.
- WB_DATA  out  INPUT_WIDTH  result value.

## Operation
- States: IDLE, EXEC, DRAIN, WB.
- BUSY = (state != IDLE).
- Accept = ISSUE_VALID & !BUSY & !FLUSH. On accept, funct3/rs1/rs2/rd are latched into the operand registers, which drive M_CNT/M_RS1/M_RS2 directly.
- IDLE → EXEC on accept when rd != 0 and there is no cache hit.
- Accept with rd == 0: the instruction retires silently. State stays IDLE, no launch, no WB_VALID.
- Cache hit (cache valid and funct3/rs1/rs2 all equal the cached entry): IDLE → WB with WB_DATA = cached result. RV32M is not launched.
- EXEC:
  - M_START = 1.
  - On M_READY: capture M_OUT into WB_DATA and into the cache (funct3, rs1, rs2, result; cache valid = 1), then go to WB.
  - On FLUSH without M_READY: go to DRAIN.
  - If FLUSH and M_READY arrive in the same cycle: result is cached but not written back; go to IDLE.
- DRAIN:
  - M_START stays 1 and operands are held.
  - On M_READY: update the cache, then IDLE. No WB_VALID.
  - FLUSH has no effect in DRAIN.
- WB:
  - WB_VALID = 1 and holds while PIPE_STALL.
  - Leaves to IDLE in the first cycle with !PIPE_STALL.
  - FLUSH in WB → IDLE, with WB_VALID low from the next cycle.
- M_START = 0 in IDLE and WB. This guarantees at least one START-low cycle between launches, so a stale READY is never sampled.
- Operand registers change only on accept. Values on M_CNT/M_RS1/M_RS2 stay constant from launch to M_READY.
- The cache is cleared only by RST. FLUSH leaves it valid because its contents are architecturally correct.

## Timing
- Reset state:
  - state IDLE, cache invalid, operand registers 0.
  - BUSY 0, M_START 0, M_CNT 0, M_RS1/M_RS2 0.
  - WB_VALID 0, WB_RD 0, WB_DATA 0.
- Launch: accept at edge N; M_START = 1 in cycle N+1.
- Completion: M_READY sampled high at edge K (in EXEC); WB_VALID = 1 in cycle K+1. Total latency = RV32M latency + 2.
- Cache hit: accept at edge N; WB_VALID = 1 in cycle N+1.
- Minimum issue-to-issue spacing: launch path 3 cycles plus RV32M latency; cache-hit path 2 cycles.
- A writeback handshake completes on any cycle where WB_VALID & !PIPE_STALL.
- FLUSH takes priority over accept and over writeback in the same cycle.
- RST mid-operation:
  - Immediately returns to IDLE and invalidates the cache.
  - RV32M is left to settle; its READY is ignored outside EXEC/DRAIN.

## Structure
- Shared package m_ext_pkg holds:
  - the funct3 constants MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (3'b000..3'b111);
  - the state encoding (IDLE, EXEC, DRAIN, WB, 2 bits).
- One sub-module, m_ext_result_cache: tag compare plus data register, with ports for lookup, update and clear. The FSM and the operand/WB registers live in m_ext_issue.
- RV32M is instantiated by the parent, not inside this block.

## Test plan
- MUL, rs1=7, rs2=6, rd=5 → M_START high from N+1 until READY; then WB_VALID with WB_RD=5, WB_DATA=42.
- Repeat the same MUL 7×6 into rd=9 → no M_START pulse; WB_VALID at N+1 with WB_DATA=42, WB_RD=9.
- DIV 0x80000000 / 0xFFFFFFFF with FLUSH one cycle after launch → DRAIN until READY; no WB_VALID; BUSY low afterwards. Re-issuing the same op then hits the cache with 0x80000000.
- REMU 100 % 7, PIPE_STALL held for 3 cycles after completion → WB_VALID=1 and WB_DATA=2 stable for 4 cycles; IDLE after release.
- Issue with rd=0 (MULHU 0xFFFFFFFF×2) → BUSY stays 0, M_START stays 0, WB_VALID stays 0.
- RST asserted during EXEC → next cycle all outputs 0, state IDLE; the following identical op relaunches because the cache was cleared.
